mips_prog_loader: RTL
=====================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction-memory depth in words; ADDR_W = clog2(DEPTH).
REQ-002 SHALL have ports clk (in, 1, single clock) and rst_n (in, 1, reset, asynchronous, active-low).
REQ-003 SHALL have port start (in, 1, begins a load session at word address 0).
REQ-004 SHALL have port finish (in, 1, ends the session early).
REQ-005 SHALL have request ports: req_valid (in, 1); req_ready (out, 1); req_op (in, 3, 000 RTYPE, 001 LW, 010 SW, 011 BEQ, 100 ADDI, 101 J); req_fsel (in, 3, RTYPE function select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 NOP).
REQ-006 SHALL have operand ports req_rs, req_rt, req_rd (in, 5 each), req_imm (in, 16) and req_target (in, 26).
REQ-007 SHALL have memory write ports: imem_we (out, 1); imem_addr (out, ADDR_W, word address); imem_wdata (out, 32, encoded instruction).
REQ-008 SHALL have status ports: busy (out, 1); done (out, 1); err (out, 1, sticky); instr_count (out, ADDR_W+1, words written).

Function
REQ-009 SHALL implement the FSM states IDLE, LOAD, WRITE and DONE.
REQ-010 IDLE: start=1 -> LOAD; imem_addr and instr_count clear to 0; err clears.
REQ-011 LOAD: req_ready = ~finish.
- finish=1 -> DONE.
- Handshake (req_valid & req_ready) with a legal op: the encoded word registers into imem_wdata; next state WRITE.
REQ-012 WRITE: imem_we=1 for exactly one cycle.
- Next cycle: imem_addr increments by 1 and instr_count increments by 1.
- Next state LOAD, or DONE if the written address was DEPTH-1; no wrap-around.
REQ-013 Latency: handshake in cycle N -> imem_we=1 in cycle N+1; peak throughput is one word per 2 cycles.
REQ-014 Illegal request (req_op 110/111, or RTYPE with req_fsel 110/111):
- Is accepted (handshake completes).
- Sets err=1.
- Writes nothing and stays in LOAD.
REQ-015 DONE: done=1. start=1 -> LOAD with the same clearing as REQ-010; otherwise remain in DONE.
REQ-016 start SHALL be ignored in LOAD and WRITE. finish SHALL be ignored in IDLE, WRITE and DONE.
REQ-017 busy SHALL be 1 in LOAD and WRITE. req_ready SHALL be 0 in IDLE, WRITE and DONE.
REQ-018 Encoding, MSB first:
- RTYPE: {000000, rs, rt, rd, 00000, funct}, funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010; RTYPE NOP encodes as 32'h00000000.
- LW: {100011, rs, rt, imm}.
- SW: {101011, rs, rt, imm}.
- BEQ: {000100, rs, rt, imm}.
- ADDI: {001000, rs, rt, imm}.
- J: {000010, target}.
- Fields are copied unmodified, with no sign extension.
REQ-019 imem_wdata and imem_addr SHALL be stable while imem_we=1.
REQ-020 Operand inputs SHALL be sampled only on a handshake cycle.

Reset
REQ-021 rst_n=0 SHALL immediately and asynchronously force:
- state IDLE;
- imem_we=0, imem_addr=0, imem_wdata=0;
- req_ready=0, busy=0, done=0, err=0, instr_count=0.
REQ-022 Reset asserted mid-WRITE SHALL suppress that write within the same cycle.
REQ-023 After rst_n deasserts, the FSM SHALL need a new start to leave IDLE.

Verification
REQ-024 start; ADD rs=1 rt=2 rd=3 -> imem_we one cycle later, addr 0, wdata 0x00221820, instr_count 1.
REQ-025 LW rs=0 rt=8 imm=0x0004, then J target=0x10, then BEQ rs=1 rt=2 imm=0xFFFF -> 0x8C080004 @0, 0x08000010 @1, 0x1022FFFF @2.
REQ-026 req_op=111 offered, then SUB rs=1 rt=2 rd=3 -> err=1, no write for the illegal op, 0x00221822 @0.
REQ-027 DEPTH=4, 5 back-to-back requests -> writes @0..3, then done=1, req_ready=0, 5th request never accepted, instr_count 4.
REQ-028 finish and req_valid asserted in the same LOAD cycle -> no handshake, DONE next cycle; a following start restarts at addr 0 with err cleared.
REQ-029 rst_n pulsed low during WRITE -> imem_we drops at once, all outputs 0; start after release -> first write at addr 0.

Source files
------------

// File: rtl/mips_prog_loader_if.sv
// Request bus between an instruction producer and the program loader.
interface mips_prog_loader_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [2:0]  req_fsel;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [15:0] req_imm;
    logic [25:0] req_target;

    modport master (
        output req_valid, req_op, req_fsel, req_rs, req_rt, req_rd, req_imm, req_target,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_fsel, req_rs, req_rt, req_rd, req_imm, req_target,
        output req_ready
    );
endinterface

// File: rtl/mips_prog_loader.sv
// Encodes MIPS instruction requests and writes them sequentially into instruction memory.
module mips_prog_loader #(
    parameter  int unsigned DEPTH  = 64,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 finish,
    mips_prog_loader_if.slave    req,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [31:0]          imem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W:0]      instr_count
);

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_LW    = 3'd1;
    localparam logic [2:0] OP_SW    = 3'd2;
    localparam logic [2:0] OP_BEQ   = 3'd3;
    localparam logic [2:0] OP_ADDI  = 3'd4;
    localparam logic [2:0] OP_J     = 3'd5;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_SLT = 3'd4;
    localparam logic [2:0] F_NOP = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_count;

    logic                w_legal;
    logic [31:0]         w_word;
    logic                w_hs;

    // Ready is combinational so a same-cycle finish blocks the handshake.
    assign req.req_ready = (r_state == S_LOAD) && !finish;
    assign w_hs          = req.req_valid && req.req_ready;

    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign instr_count = r_count;

    // Instruction encoder and legality check.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (req.req_op)
            OP_RTYPE: begin
                case (req.req_fsel)
                    F_ADD:   w_word = {6'b000000, req.req_rs, req.req_rt, req.req_rd, 5'b00000, 6'b100000};
                    F_SUB:   w_word = {6'b000000, req.req_rs, req.req_rt, req.req_rd, 5'b00000, 6'b100010};
                    F_AND:   w_word = {6'b000000, req.req_rs, req.req_rt, req.req_rd, 5'b00000, 6'b100100};
                    F_OR:    w_word = {6'b000000, req.req_rs, req.req_rt, req.req_rd, 5'b00000, 6'b100101};
                    F_SLT:   w_word = {6'b000000, req.req_rs, req.req_rt, req.req_rd, 5'b00000, 6'b101010};
                    F_NOP:   w_word = '0;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LW:   w_word = {6'b100011, req.req_rs, req.req_rt, req.req_imm};
            OP_SW:   w_word = {6'b101011, req.req_rs, req.req_rt, req.req_imm};
            OP_BEQ:  w_word = {6'b000100, req.req_rs, req.req_rt, req.req_imm};
            OP_ADDI: w_word = {6'b001000, req.req_rs, req.req_rt, req.req_imm};
            OP_J:    w_word = {6'b000010, req.req_target};
            default: w_legal = 1'b0;
        endcase
    end

    // Session FSM with registered status and memory-write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (finish) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_hs) begin
                        if (w_legal) begin
                            r_wdata <= w_word;
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + (ADDR_W+1)'(1);
                    // Last word: hold the address rather than wrap.
                    if (r_addr == LAST_ADDR) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
